// File: rtl/viterbi_pkg.sv
// Shared constants for the Viterbi depuncturer and transmit-side puncturer:
// rate codes and X/Y puncturing patterns (bit k of a pattern is column k).
package viterbi_pkg;

  localparam logic [2:0] RATE_1_2 = 3'd0;
  localparam logic [2:0] RATE_2_3 = 3'd1;
  localparam logic [2:0] RATE_3_4 = 3'd2;
  localparam logic [2:0] RATE_5_6 = 3'd3;
  localparam logic [2:0] RATE_7_8 = 3'd4;

  localparam int P_MAX_PERIOD = 7;

  localparam logic [P_MAX_PERIOD-1:0] PAT_X_1_2 = 7'b0000001;
  localparam logic [P_MAX_PERIOD-1:0] PAT_Y_1_2 = 7'b0000001;
  localparam logic [P_MAX_PERIOD-1:0] PAT_X_2_3 = 7'b0000001;
  localparam logic [P_MAX_PERIOD-1:0] PAT_Y_2_3 = 7'b0000011;
  localparam logic [P_MAX_PERIOD-1:0] PAT_X_3_4 = 7'b0000101;
  localparam logic [P_MAX_PERIOD-1:0] PAT_Y_3_4 = 7'b0000011;
  localparam logic [P_MAX_PERIOD-1:0] PAT_X_5_6 = 7'b0010101;
  localparam logic [P_MAX_PERIOD-1:0] PAT_Y_5_6 = 7'b0001011;
  localparam logic [P_MAX_PERIOD-1:0] PAT_X_7_8 = 7'b1010001;
  localparam logic [P_MAX_PERIOD-1:0] PAT_Y_7_8 = 7'b0101111;

  // Unused codes fall back to the unpunctured rate.
  function automatic logic [2:0] rate_norm(input logic [2:0] rate);
    return (rate > RATE_7_8) ? RATE_1_2 : rate;
  endfunction

  function automatic logic [P_MAX_PERIOD-1:0] pat_x(input logic [2:0] rate);
    case (rate_norm(rate))
      RATE_2_3: return PAT_X_2_3;
      RATE_3_4: return PAT_X_3_4;
      RATE_5_6: return PAT_X_5_6;
      RATE_7_8: return PAT_X_7_8;
      default:  return PAT_X_1_2;
    endcase
  endfunction

  function automatic logic [P_MAX_PERIOD-1:0] pat_y(input logic [2:0] rate);
    case (rate_norm(rate))
      RATE_2_3: return PAT_Y_2_3;
      RATE_3_4: return PAT_Y_3_4;
      RATE_5_6: return PAT_Y_5_6;
      RATE_7_8: return PAT_Y_7_8;
      default:  return PAT_Y_1_2;
    endcase
  endfunction

  function automatic logic [2:0] pat_period(input logic [2:0] rate);
    case (rate_norm(rate))
      RATE_2_3: return 3'd2;
      RATE_3_4: return 3'd3;
      RATE_5_6: return 3'd5;
      RATE_7_8: return 3'd7;
      default:  return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/viterbi_punct_rom.sv
// Combinational puncturing-pattern lookup: (rate, column) -> X, Y and
// whether the column is the last of the pattern period.
module viterbi_punct_rom
  import viterbi_pkg::*;
(
  input  logic [2:0] rate,
  input  logic [2:0] col,
  output logic       x_bit,
  output logic       y_bit,
  output logic       last_col
);

  logic [P_MAX_PERIOD-1:0] x_pat;
  logic [P_MAX_PERIOD-1:0] y_pat;
  logic [2:0]              period;

  always_comb begin
    x_pat    = pat_x(rate);
    y_pat    = pat_y(rate);
    period   = pat_period(rate);
    x_bit    = x_pat[col];
    y_bit    = y_pat[col];
    last_col = (col == period - 3'd1);
  end

endmodule

// File: rtl/viterbi_depuncture.sv
// Depuncturer: rebuilds (G0, G1) soft pairs from a punctured symbol stream,
// inserting erasures at punctured positions, with ready/valid on both sides.
module viterbi_depuncture
  import viterbi_pkg::*;
#(
  parameter int                  P_SOFT_W    = 3,
  parameter logic [P_SOFT_W-1:0] P_ERASE_VAL = '0
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [2:0]            i_rate,
  input  logic                  i_sync,
  input  logic [P_SOFT_W-1:0]   i_sym,
  input  logic                  i_sym_valid,
  output logic                  o_sym_ready,
  output logic [2*P_SOFT_W-1:0] o_data,
  output logic [1:0]            o_erase,
  output logic                  o_valid,
  input  logic                  i_ready
);

  logic [2:0]            col_reg, col_next;
  logic                  half_reg, half_next;
  logic [P_SOFT_W-1:0]   a0_reg, a0_next;
  logic [2:0]            rate_reg;
  logic [2*P_SOFT_W-1:0] data_reg, data_next;
  logic [1:0]            erase_reg, erase_next;
  logic                  valid_reg;

  logic       accept;
  logic       restart;
  logic       complete;
  logic [2:0] eff_rate;
  logic [2:0] eff_col;
  logic       eff_half;
  logic       x_bit, y_bit, last_col;

  assign o_sym_ready = !valid_reg || i_ready;
  assign accept      = i_sym_valid && o_sym_ready;

  // A period boundary (or a sync) lets the presented rate govern this symbol.
  assign restart  = i_sync || (col_reg == 3'd0 && !half_reg);
  assign eff_rate = restart ? i_rate : rate_reg;
  assign eff_col  = i_sync ? 3'd0 : col_reg;
  assign eff_half = i_sync ? 1'b0 : half_reg;

  viterbi_punct_rom u_rom (
    .rate     (eff_rate),
    .col      (eff_col),
    .x_bit    (x_bit),
    .y_bit    (y_bit),
    .last_col (last_col)
  );

  always_comb begin
    col_next   = eff_col;
    half_next  = eff_half;
    a0_next    = a0_reg;
    data_next  = data_reg;
    erase_next = erase_reg;
    complete   = 1'b0;

    if (x_bit && y_bit) begin
      if (!eff_half) begin
        a0_next   = i_sym;
        half_next = 1'b1;
      end else begin
        data_next  = {i_sym, a0_reg};
        erase_next = 2'b00;
        complete   = 1'b1;
      end
    end else if (x_bit) begin
      data_next  = {P_ERASE_VAL, i_sym};
      erase_next = 2'b10;
      complete   = 1'b1;
    end else begin
      data_next  = {i_sym, P_ERASE_VAL};
      erase_next = 2'b01;
      complete   = 1'b1;
    end

    if (complete) begin
      half_next = 1'b0;
      col_next  = last_col ? 3'd0 : eff_col + 3'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      col_reg  <= '0;
      half_reg <= 1'b0;
      a0_reg   <= '0;
      rate_reg <= RATE_1_2;
    end else if (accept) begin
      col_reg  <= col_next;
      half_reg <= half_next;
      a0_reg   <= a0_next;
      if (restart) rate_reg <= i_rate;
    end
  end

  // Output register: reload on completion, otherwise drain on i_ready.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      data_reg  <= '0;
      erase_reg <= 2'b00;
      valid_reg <= 1'b0;
    end else if (accept && complete) begin
      data_reg  <= data_next;
      erase_reg <= erase_next;
      valid_reg <= 1'b1;
    end else if (i_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign o_data  = data_reg;
  assign o_erase = erase_reg;
  assign o_valid = valid_reg;

endmodule

// File: tb/tb_viterbi_depuncture.sv
// Directed self-checking bench for viterbi_depuncture: pairing, erasure
// insertion, backpressure, rate switching, sync and asynchronous reset.
module tb_viterbi_depuncture;

  localparam int          W = 3;
  localparam logic [W-1:0] E = 3'b100;

  logic           i_clk = 1'b0;
  logic           i_reset_n;
  logic [2:0]     i_rate;
  logic           i_sync;
  logic [W-1:0]   i_sym;
  logic           i_sym_valid;
  logic           o_sym_ready;
  logic [2*W-1:0] o_data;
  logic [1:0]     o_erase;
  logic           o_valid;
  logic           i_ready;

  int n_tests = 0;
  int n_fail  = 0;

  viterbi_depuncture #(.P_SOFT_W(W), .P_ERASE_VAL(E)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_rate      (i_rate),
    .i_sync      (i_sync),
    .i_sym       (i_sym),
    .i_sym_valid (i_sym_valid),
    .o_sym_ready (o_sym_ready),
    .o_data      (o_data),
    .o_erase     (o_erase),
    .o_valid     (o_valid),
    .i_ready     (i_ready)
  );

  always #5 i_clk = ~i_clk;

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic send(input logic [W-1:0] s, input logic v, input logic sy,
                      input logic [2:0] r, input logic rdy);
    i_sym = s; i_sym_valid = v; i_sync = sy; i_rate = r; i_ready = rdy;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      $display("[TB] %s ok (%0h)", tag, obs);
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check one output pair; G0 in the low half, G1 in the high half.
  task automatic chk_pair(input string tag, input logic [W-1:0] g0,
                          input logic [W-1:0] g1, input logic [1:0] er);
    logic [2*W-1:0] exp_data;
    exp_data = {g1, g0};
    chk({tag, ".valid"}, 32'(o_valid), 32'd1);
    chk({tag, ".data"},  32'(o_data),  32'(exp_data));
    chk({tag, ".erase"}, 32'(o_erase), 32'(er));
  endtask

  initial begin
    i_reset_n = 1'b0; i_rate = 3'd0; i_sync = 1'b0; i_sym = '0;
    i_sym_valid = 1'b0; i_ready = 1'b1;
    #1;
    chk("reset.valid", 32'(o_valid), 32'd0);
    chk("reset.data",  32'(o_data),  32'd0);
    chk("reset.erase", 32'(o_erase), 32'd0);
    chk("reset.ready", 32'(o_sym_ready), 32'd1);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;

    // Rate 1/2: 1,2,3,4 -> (1,2),(3,4)
    send(3'd1, 1, 0, 3'd0, 1); chk("r12.s1", 32'(o_valid), 32'd0);
    send(3'd2, 1, 0, 3'd0, 1); chk_pair("r12.p0", 3'd1, 3'd2, 2'b00);
    send(3'd3, 1, 0, 3'd0, 1); chk("r12.s3", 32'(o_valid), 32'd0);
    send(3'd4, 1, 0, 3'd0, 1); chk_pair("r12.p1", 3'd3, 3'd4, 2'b00);
    send(3'd0, 0, 0, 3'd0, 1); chk("r12.idle", 32'(o_valid), 32'd0);

    // Rate 3/4: 5,6,7,1 -> (5,6) 00, (E,7) 01, (1,E) 10, then column 0 again
    send(3'd5, 1, 0, 3'd2, 1); chk("r34.s5", 32'(o_valid), 32'd0);
    send(3'd6, 1, 0, 3'd2, 1); chk_pair("r34.p0", 3'd5, 3'd6, 2'b00);
    send(3'd7, 1, 0, 3'd2, 1); chk_pair("r34.p1", E, 3'd7, 2'b01);
    send(3'd1, 1, 0, 3'd2, 1); chk_pair("r34.p2", 3'd1, E, 2'b10);
    send(3'd2, 1, 0, 3'd2, 1); chk("r34.wrap", 32'(o_valid), 32'd0);
    send(3'd3, 1, 0, 3'd2, 1); chk_pair("r34.p3", 3'd2, 3'd3, 2'b00);
    send(3'd7, 1, 0, 3'd2, 1); chk_pair("r34.p4", E, 3'd7, 2'b01);
    send(3'd1, 1, 0, 3'd2, 1); chk_pair("r34.p5", 3'd1, E, 2'b10);

    // Rate 7/8 with 3 cycles of backpressure after the first pair
    send(3'd1, 1, 0, 3'd4, 1); chk("r78.s1", 32'(o_valid), 32'd0);
    send(3'd2, 1, 0, 3'd4, 1); chk_pair("r78.p0", 3'd1, 3'd2, 2'b00);
    for (int i = 0; i < 3; i++) begin
      send(3'd3, 1, 0, 3'd4, 0);
      chk_pair($sformatf("r78.hold%0d", i), 3'd1, 3'd2, 2'b00);
      chk($sformatf("r78.hold%0d.rdy", i), 32'(o_sym_ready), 32'd0);
    end
    send(3'd3, 1, 0, 3'd4, 1); chk_pair("r78.c1", E, 3'd3, 2'b01);
    send(3'd5, 1, 0, 3'd4, 1); chk_pair("r78.c2", E, 3'd5, 2'b01);
    send(3'd6, 1, 0, 3'd4, 1); chk_pair("r78.c3", E, 3'd6, 2'b01);
    send(3'd7, 1, 0, 3'd4, 1); chk_pair("r78.c4", 3'd7, E, 2'b10);
    send(3'd1, 1, 0, 3'd4, 1); chk_pair("r78.c5", E, 3'd1, 2'b01);
    send(3'd2, 1, 0, 3'd4, 1); chk_pair("r78.c6", 3'd2, E, 2'b10);

    // Rate switch 2/3 -> 1/2 presented at column 1 only takes effect at wrap
    send(3'd1, 1, 0, 3'd1, 1); chk("sw.s1", 32'(o_valid), 32'd0);
    send(3'd2, 1, 0, 3'd1, 1); chk_pair("sw.p0", 3'd1, 3'd2, 2'b00);
    send(3'd3, 1, 0, 3'd0, 1); chk_pair("sw.p1", E, 3'd3, 2'b01);
    send(3'd5, 1, 0, 3'd0, 1); chk("sw.s5", 32'(o_valid), 32'd0);
    send(3'd6, 1, 0, 3'd0, 1); chk_pair("sw.p2", 3'd5, 3'd6, 2'b00);
    send(3'd7, 1, 0, 3'd0, 1); chk("sw.s7", 32'(o_valid), 32'd0);
    send(3'd1, 1, 0, 3'd0, 1); chk_pair("sw.p3", 3'd7, 3'd1, 2'b00);

    // Sync with a half-assembled pair at 2/3 drops the partial a0
    send(3'd1, 1, 0, 3'd1, 1); chk("sync.s1", 32'(o_valid), 32'd0);
    send(3'd5, 1, 1, 3'd1, 1); chk("sync.s5", 32'(o_valid), 32'd0);
    send(3'd6, 1, 0, 3'd1, 1); chk_pair("sync.p0", 3'd5, 3'd6, 2'b00);
    send(3'd7, 1, 0, 3'd1, 1); chk_pair("sync.p1", E, 3'd7, 2'b01);

    // Async reset with o_valid high
    send(3'd1, 1, 0, 3'd0, 1);
    send(3'd2, 1, 0, 3'd0, 1); chk_pair("rst.pre", 3'd1, 3'd2, 2'b00);
    #2 i_reset_n = 1'b0;
    #1;
    chk("rst.valid", 32'(o_valid), 32'd0);
    chk("rst.data",  32'(o_data),  32'd0);
    chk("rst.erase", 32'(o_erase), 32'd0);
    chk("rst.ready", 32'(o_sym_ready), 32'd1);
    #2 i_reset_n = 1'b1;

    // Async reset mid-column (h=1) at 3/4, then 1/2 pairing from first symbol
    send(3'd5, 1, 0, 3'd2, 1); chk("rst2.h1", 32'(o_valid), 32'd0);
    #2 i_reset_n = 1'b0;
    #3 i_reset_n = 1'b1;
    send(3'd1, 1, 0, 3'd0, 1); chk("rst2.s1", 32'(o_valid), 32'd0);
    send(3'd2, 1, 0, 3'd0, 1); chk_pair("rst2.p0", 3'd1, 3'd2, 2'b00);

    // Reserved rate code behaves as 1/2
    send(3'd3, 1, 0, 3'd6, 1); chk("r6.s3", 32'(o_valid), 32'd0);
    send(3'd5, 1, 0, 3'd6, 1); chk_pair("r6.p0", 3'd3, 3'd5, 2'b00);
    send(3'd0, 0, 0, 3'd6, 1); chk("r6.idle", 32'(o_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
